cute_lock_key_sequencer: RTL and testbench

//  Upstream key-delivery stage for the counter-keyed (Cute-Lock structural) locked FSMs.

---
 rtl/cute_lock_key_sequencer_pkg.sv | 21 ++
 rtl/cute_lock_key_sequencer_if.sv | 35 +++
 rtl/cute_lock_key_sequencer_loader.sv | 35 +++
 rtl/cute_lock_key_sequencer.sv | 130 +++++++++++++
 tb/tb_cute_lock_key_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cute_lock_key_sequencer_pkg.sv
// Shared types and sizing helpers for the Cute-Lock key sequencer.
// Holds the FSM state encoding, the counter-width rule and the key-store width rule.
package cute_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_t;

    // Counter width for an n-entry schedule; never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int flat_width(input int num_states, input int key_width);
        return num_states * key_width;
    endfunction

endpackage

// File: rtl/cute_lock_key_sequencer_if.sv
// Control/status bundle between the activation interface and the key sequencer.
// The master drives load/run controls and the serial key; the slave returns the key stream.
interface cute_lock_key_sequencer_if
    import cute_lock_pkg::*;
#(
    parameter int KEY_WIDTH  = 2,
    parameter int NUM_STATES = 2
) ();
    localparam int CW = cw_of(NUM_STATES);

    logic                 load_start;
    logic                 load_abort;
    logic                 key_sdi;
    logic                 key_sdi_valid;
    logic                 run_start;
    logic                 run_stop;
    logic                 sync_clear;
    logic [KEY_WIDTH-1:0] keyinput;
    logic [CW-1:0]        count_state;
    logic                 key_loaded;
    logic                 running;

    modport master (
        output load_start, load_abort, key_sdi, key_sdi_valid,
        output run_start, run_stop, sync_clear,
        input  keyinput, count_state, key_loaded, running
    );

    modport slave (
        input  load_start, load_abort, key_sdi, key_sdi_valid,
        input  run_start, run_stop, sync_clear,
        output keyinput, count_state, key_loaded, running
    );

endinterface

// File: rtl/cute_lock_key_sequencer_loader.sv
// Serial key-schedule loader: shifts bits into a flat store, first bit at the LSB.
// done is combinational so the FSM can arm on the same edge that stores the last bit.
module key_seq_loader
    import cute_lock_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         take,
    input  logic         bit_in,
    output logic [N-1:0] store,
    output logic         done
);
    localparam int BW = cw_of(N);

    logic [BW-1:0] bit_cnt_reg;
    logic [N-1:0]  store_reg;

    assign done  = take && (bit_cnt_reg == BW'(N - 1));
    assign store = store_reg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            bit_cnt_reg <= '0;
            store_reg   <= '0;
        end else if (take) begin
            store_reg[bit_cnt_reg] <= bit_in;
            // Return to zero after the last bit so the count never leaves 0..N-1.
            bit_cnt_reg <= done ? '0 : bit_cnt_reg + BW'(1);
        end
    end

endmodule

// File: rtl/cute_lock_key_sequencer.sv
// Key-delivery stage for counter-keyed locked FSMs: loads a serial key schedule, then
// presents one registered key word per cycle, indexed by a counter that wraps modulo NUM_STATES.
module cute_lock_key_sequencer
    import cute_lock_pkg::*;
#(
    parameter int KEY_WIDTH  = 2,
    parameter int NUM_STATES = 2
) (
    input  logic clock,
    input  logic reset,
    cute_lock_key_sequencer_if.slave bus
);
    localparam int CW = cw_of(NUM_STATES);
    localparam int N  = flat_width(NUM_STATES, KEY_WIDTH);

    seq_state_t state_reg, state_next;

    logic [KEY_WIDTH-1:0] keyinput_reg, keyinput_next;
    logic [CW-1:0]        count_reg, count_next, count_inc;
    logic                 key_loaded_reg, key_loaded_next;

    logic                 clear, take, done;
    logic [N-1:0]         store;
    logic [KEY_WIDTH-1:0] words [NUM_STATES];

    key_seq_loader #(.N(N)) u_loader (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .take   (take),
        .bit_in (bus.key_sdi),
        .store  (store),
        .done   (done)
    );

    for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_words
        assign words[gi] = store[gi*KEY_WIDTH +: KEY_WIDTH];
    end

    assign count_inc = (count_reg == CW'(NUM_STATES - 1)) ? '0 : count_reg + CW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            keyinput_reg   <= '0;
            count_reg      <= '0;
            key_loaded_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            keyinput_reg   <= keyinput_next;
            count_reg      <= count_next;
            key_loaded_reg <= key_loaded_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (bus.load_start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (bus.load_abort)      state_next = ST_IDLE;
                else if (bus.load_start) state_next = ST_LOAD;
                else if (done)           state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (bus.load_start)     state_next = ST_LOAD;
                else if (bus.run_start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.load_start)    state_next = ST_LOAD;
                else if (bus.run_stop) state_next = ST_ARMED;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        clear           = 1'b0;
        take            = 1'b0;
        keyinput_next   = keyinput_reg;
        count_next      = count_reg;
        key_loaded_next = key_loaded_reg;
        unique case (state_reg)
            ST_IDLE: clear = bus.load_start;
            ST_LOAD: begin
                // Abort and restart both discard any partial key, even with a valid bit present.
                if (bus.load_abort || bus.load_start) begin
                    clear = 1'b1;
                end else begin
                    take = bus.key_sdi_valid;
                    if (done) key_loaded_next = 1'b1;
                end
            end
            ST_ARMED: begin
                if (bus.load_start) begin
                    clear           = 1'b1;
                    key_loaded_next = 1'b0;
                end else if (bus.run_start) begin
                    count_next    = '0;
                    keyinput_next = words[0];
                end
            end
            ST_RUN: begin
                if (bus.load_start) begin
                    clear           = 1'b1;
                    key_loaded_next = 1'b0;
                    keyinput_next   = '0;
                    count_next      = '0;
                end else if (bus.run_stop) begin
                    keyinput_next = '0;
                    count_next    = '0;
                end else if (bus.sync_clear) begin
                    keyinput_next = words[0];
                    count_next    = '0;
                end else begin
                    // Word is fetched for the next index so keyinput always matches count_state.
                    keyinput_next = words[count_inc];
                    count_next    = count_inc;
                end
            end
            default: ;
        endcase
    end

    assign bus.keyinput    = keyinput_reg;
    assign bus.count_state = count_reg;
    assign bus.key_loaded  = key_loaded_reg;
    assign bus.running     = (state_reg == ST_RUN);

endmodule

// File: tb/tb_cute_lock_key_sequencer.sv
// Directed bench for the key sequencer: a 2x2 instance and a 3x3 instance share clock and reset.
module tb_cute_lock_key_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    cute_lock_key_sequencer_if #(.KEY_WIDTH(2), .NUM_STATES(2)) bus_a ();
    cute_lock_key_sequencer_if #(.KEY_WIDTH(3), .NUM_STATES(3)) bus_b ();

    cute_lock_key_sequencer #(.KEY_WIDTH(2), .NUM_STATES(2)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    cute_lock_key_sequencer #(.KEY_WIDTH(3), .NUM_STATES(3)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bus_b)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_a(input logic b, input int gap = 0);
        bus_a.key_sdi       = b;
        bus_a.key_sdi_valid = 1'b1;
        step();
        bus_a.key_sdi_valid = 1'b0;
        bus_a.key_sdi       = ~b;
        step(gap);
    endtask

    task automatic send_b(input logic b);
        bus_b.key_sdi       = b;
        bus_b.key_sdi_valid = 1'b1;
        step();
        bus_b.key_sdi_valid = 1'b0;
    endtask

    task automatic pulse_a_load();
        bus_a.load_start = 1'b1;
        step();
        bus_a.load_start = 1'b0;
    endtask

    task automatic pulse_a_run();
        bus_a.run_start = 1'b1;
        step();
        bus_a.run_start = 1'b0;
    endtask

    logic [1:0] exp_ki2 [4];
    logic [2:0] exp_ki3 [6];
    logic [3:0] bits_a;
    logic [8:0] bits_b;

    initial begin
        {bus_a.load_start, bus_a.load_abort, bus_a.key_sdi, bus_a.key_sdi_valid} = '0;
        {bus_a.run_start, bus_a.run_stop, bus_a.sync_clear} = '0;
        {bus_b.load_start, bus_b.load_abort, bus_b.key_sdi, bus_b.key_sdi_valid} = '0;
        {bus_b.run_start, bus_b.run_stop, bus_b.sync_clear} = '0;

        // 1: reset, load 1,0,1,1, run
        step(2);
        rst = 1'b0;
        chk("rst_ki", 32'(bus_a.keyinput), 0);
        chk("rst_cnt", 32'(bus_a.count_state), 0);
        chk("rst_loaded", 32'(bus_a.key_loaded), 0);
        chk("rst_run", 32'(bus_a.running), 0);
        pulse_a_load();
        bits_a = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            send_a(bits_a[i]);
            chk("t1_loaded", 32'(bus_a.key_loaded), (i == 3) ? 1 : 0);
        end
        chk("t1_armed_ki", 32'(bus_a.keyinput), 0);
        chk("t1_armed_run", 32'(bus_a.running), 0);
        pulse_a_run();
        exp_ki2 = '{2'b01, 2'b11, 2'b01, 2'b11};
        for (int i = 0; i < 4; i++) begin
            chk("t1_ki", 32'(bus_a.keyinput), 32'(exp_ki2[i]));
            chk("t1_cnt", 32'(bus_a.count_state), i % 2);
            step();
        end

        // 2: reload from RUN with 3-cycle gaps between bits
        pulse_a_load();
        chk("t2_ld_ki", 32'(bus_a.keyinput), 0);
        chk("t2_ld_loaded", 32'(bus_a.key_loaded), 0);
        for (int i = 0; i < 4; i++) begin
            send_a(bits_a[i], 3);
            chk("t2_loaded", 32'(bus_a.key_loaded), (i == 3) ? 1 : 0);
        end
        pulse_a_run();
        for (int i = 0; i < 3; i++) begin
            chk("t2_ki", 32'(bus_a.keyinput), 32'(exp_ki2[i]));
            step();
        end

        // 3: abort after two bits (abort with a valid bit pending), then reload 0,1,1,0
        pulse_a_load();
        send_a(1'b1);
        send_a(1'b1);
        bus_a.load_abort    = 1'b1;
        bus_a.key_sdi_valid = 1'b1;
        step();
        bus_a.load_abort    = 1'b0;
        bus_a.key_sdi_valid = 1'b0;
        chk("t3_ab_loaded", 32'(bus_a.key_loaded), 0);
        send_a(1'b1);
        send_a(1'b1);
        chk("t3_idle_bits", 32'(bus_a.key_loaded), 0);
        pulse_a_run();
        chk("t3_idle_run", 32'(bus_a.running), 0);
        pulse_a_load();
        bits_a = 4'b0110;
        for (int i = 0; i < 4; i++) send_a(bits_a[i]);
        chk("t3_loaded", 32'(bus_a.key_loaded), 1);
        pulse_a_run();
        exp_ki2 = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            chk("t3_ki", 32'(bus_a.keyinput), 32'(exp_ki2[i]));
            step();
        end

        // 4: sync_clear with run_stop at count 1 -> stop wins; sync_clear alone at count 0
        chk("t4_pre_cnt", 32'(bus_a.count_state), 1);
        bus_a.sync_clear = 1'b1;
        bus_a.run_stop   = 1'b1;
        step();
        bus_a.run_stop   = 1'b0;
        bus_a.sync_clear = 1'b0;
        chk("t4_stop_run", 32'(bus_a.running), 0);
        chk("t4_stop_ki", 32'(bus_a.keyinput), 0);
        chk("t4_stop_cnt", 32'(bus_a.count_state), 0);
        pulse_a_run();
        chk("t4_rerun_ki", 32'(bus_a.keyinput), 32'h2);
        bus_a.sync_clear = 1'b1;
        step();
        bus_a.sync_clear = 1'b0;
        chk("t4_sc_cnt", 32'(bus_a.count_state), 0);
        chk("t4_sc_ki", 32'(bus_a.keyinput), 32'h2);
        step();
        chk("t4_after_cnt", 32'(bus_a.count_state), 1);

        // 5: 3x3 instance, words 7,0,5
        bus_b.load_start = 1'b1;
        step();
        bus_b.load_start = 1'b0;
        bits_b = 9'b101_000_111;
        for (int i = 0; i < 9; i++) send_b(bits_b[i]);
        chk("t5_loaded", 32'(bus_b.key_loaded), 1);
        bus_b.run_start = 1'b1;
        step();
        bus_b.run_start = 1'b0;
        exp_ki3 = '{3'd7, 3'd0, 3'd5, 3'd7, 3'd0, 3'd5};
        for (int i = 0; i < 6; i++) begin
            chk("t5_ki", 32'(bus_b.keyinput), 32'(exp_ki3[i]));
            chk("t5_cnt", 32'(bus_b.count_state), i % 3);
            step();
        end
        step();
        chk("t5_pre_sc", 32'(bus_b.count_state), 1);
        bus_b.sync_clear = 1'b1;
        step();
        bus_b.sync_clear = 1'b0;
        chk("t5_sc_cnt", 32'(bus_b.count_state), 0);
        chk("t5_sc_ki", 32'(bus_b.keyinput), 7);
        bus_b.load_start = 1'b1;
        bus_b.run_stop   = 1'b1;
        step();
        bus_b.load_start = 1'b0;
        bus_b.run_stop   = 1'b0;
        chk("t5_ld_run", 32'(bus_b.running), 0);
        chk("t5_ld_loaded", 32'(bus_b.key_loaded), 0);
        chk("t5_ld_ki", 32'(bus_b.keyinput), 0);

        // 6: reset mid-LOAD and mid-RUN
        pulse_a_load();
        send_a(1'b1);
        send_a(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ld_ki", 32'(bus_a.keyinput), 0);
        chk("t6_ld_loaded", 32'(bus_a.key_loaded), 0);
        chk("t6_ld_run", 32'(bus_a.running), 0);
        chk("t6_b_loaded", 32'(bus_b.key_loaded), 0);
        send_a(1'b1);
        send_a(1'b1);
        pulse_a_run();
        chk("t6_ign_run", 32'(bus_a.running), 0);
        pulse_a_load();
        bits_a = 4'b1101;
        for (int i = 0; i < 4; i++) send_a(bits_a[i]);
        pulse_a_run();
        step();
        chk("t6_run_ki", 32'(bus_a.keyinput), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rn_ki", 32'(bus_a.keyinput), 0);
        chk("t6_rn_cnt", 32'(bus_a.count_state), 0);
        chk("t6_rn_loaded", 32'(bus_a.key_loaded), 0);
        chk("t6_rn_run", 32'(bus_a.running), 0);
        pulse_a_run();
        chk("t6_rn_ign", 32'(bus_a.running), 0);
        chk("t6_rn_ign_ki", 32'(bus_a.keyinput), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
